// File: rtl/ste_isqrt_seq_if.sv
// Radicand request / root result bundle between the RMS accumulator and the square-root responder.
// The master drives the request side, the slave (square-root block) drives the result side.
interface ste_isqrt_seq_if #(
   parameter int DATA_W    = 16,
   parameter int BUF_BIT_W = 8
);
   localparam int IN_W = 2*DATA_W + BUF_BIT_W;

   logic [IN_W-1:0]   din_i;
   logic              din_update_i;
   logic              clr_i;
   logic [DATA_W-1:0] dout_o;
   logic              dout_update_o;
   logic              busy_o;
   logic              overrun_o;
   logic              sat_o;

   modport master (
      output din_i, din_update_i, clr_i,
      input  dout_o, dout_update_o, busy_o, overrun_o, sat_o
   );

   modport slave (
      input  din_i, din_update_i, clr_i,
      output dout_o, dout_update_o, busy_o, overrun_o, sat_o
   );
endinterface

// File: rtl/ste_isqrt_seq.sv
// Restoring integer square root, one root bit per clock; strobe ITER cycles after an accepted request.
// No backpressure: requests arriving while busy are dropped and flagged by a one-cycle overrun pulse.
module ste_isqrt_seq #(
   parameter int DATA_W    = 16,
   parameter int BUF_BIT_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   ste_isqrt_seq_if.slave bus
);
   localparam int IN_W  = 2*DATA_W + BUF_BIT_W;
   localparam int ITER  = (IN_W + 1) / 2;
   localparam int RAD_W = 2*ITER;
   localparam int REM_W = ITER + 2;
   localparam int CNT_W = $clog2(ITER + 1);

   typedef enum logic {IDLE, CALC} state_t;

   state_t            state_q, state_d;
   logic [RAD_W-1:0]  rad_q, rad_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [ITER-1:0]   root_q, root_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_update_q, dout_update_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
   logic              sat_q, sat_d;

   logic [REM_W-1:0]  rem_shift;
   logic [REM_W-1:0]  trial;
   logic [REM_W-1:0]  rem_diff;
   logic [ITER-1:0]   root_next;
   logic              take;
   logic              root_sat;

   // The remainder never exceeds 2*root, so dropping the top bits of the shift loses nothing.
   always_comb begin
      rem_shift = REM_W'({rem_q, rad_q[RAD_W-1 -: 2]});
      trial     = {root_q, 2'b01};
      rem_diff  = rem_shift - trial;
      take      = (rem_shift >= trial);
      root_next = ITER'({root_q, take});
      root_sat  = |root_next[ITER-1:DATA_W];
   end

   always_comb begin
      state_d       = state_q;
      rad_d         = rad_q;
      rem_d         = rem_q;
      root_d        = root_q;
      cnt_d         = cnt_q;
      dout_d        = dout_q;
      dout_update_d = 1'b0;
      busy_d        = busy_q;
      overrun_d     = 1'b0;
      sat_d         = sat_q;

      if (bus.clr_i) begin
         state_d = IDLE;
         rad_d   = '0;
         rem_d   = '0;
         root_d  = '0;
         cnt_d   = '0;
         dout_d  = '0;
         busy_d  = 1'b0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.din_update_i) begin
                  rad_d   = RAD_W'(bus.din_i);
                  rem_d   = '0;
                  root_d  = '0;
                  cnt_d   = CNT_W'(ITER);
                  busy_d  = 1'b1;
                  state_d = CALC;
               end
            end
            CALC: begin
               overrun_d = bus.din_update_i;
               rad_d     = {rad_q[RAD_W-3:0], 2'b00};
               rem_d     = take ? rem_diff : rem_shift;
               root_d    = root_next;
               cnt_d     = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  dout_d        = root_sat ? {DATA_W{1'b1}} : root_next[DATA_W-1:0];
                  sat_d         = root_sat;
                  dout_update_d = 1'b1;
                  busy_d        = 1'b0;
                  state_d       = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rad_q         <= '0;
         rem_q         <= '0;
         root_q        <= '0;
         cnt_q         <= '0;
         dout_q        <= '0;
         dout_update_q <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         sat_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rad_q         <= rad_d;
         rem_q         <= rem_d;
         root_q        <= root_d;
         cnt_q         <= cnt_d;
         dout_q        <= dout_d;
         dout_update_q <= dout_update_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         sat_q         <= sat_d;
      end
   end

   assign bus.dout_o        = dout_q;
   assign bus.dout_update_o = dout_update_q;
   assign bus.busy_o        = busy_q;
   assign bus.overrun_o     = overrun_q;
   assign bus.sat_o         = sat_q;

endmodule

// File: tb/tb_ste_isqrt_seq.sv
// Scoreboard bench for ste_isqrt_seq: driver pushes expected results/overruns, negedge monitor pops and compares.
module tb_ste_isqrt_seq;
   localparam int DATA_W    = 16;
   localparam int BUF_BIT_W = 8;
   localparam int IN_W      = 2*DATA_W + BUF_BIT_W;
   localparam int ITER      = (IN_W + 1) / 2;
   localparam longint unsigned MAXV = (64'd1 << DATA_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ste_isqrt_seq_if #(.DATA_W(DATA_W), .BUF_BIT_W(BUF_BIT_W)) bus ();

   ste_isqrt_seq #(.DATA_W(DATA_W), .BUF_BIT_W(BUF_BIT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      longint unsigned root;
      bit              sat;
      int unsigned     edge_n;
      longint unsigned din;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned ovr_q[$];
   int unsigned cyc       = 0;
   int unsigned free_edge = 0;
   int unsigned b_start   = 0;
   int unsigned b_end     = 0;
   int          n_cmp     = 0;
   int          n_bad     = 0;
   bit          mon_on    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint unsigned isqrt_ref(input longint unsigned x);
      longint unsigned r;
      r = longint'($rtoi($sqrt(real'(x))));
      while (r * r > x) r = r - 1;
      while ((r + 1) * (r + 1) <= x) r = r + 1;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One request cycle; the model decides acceptance from edge numbers alone.
   task automatic drive_cycle(input bit upd, input logic [IN_W-1:0] d, input bit clr);
      int unsigned     e;
      longint unsigned r;
      exp_t            x;
      bus.din_update_i = upd;
      bus.din_i        = d;
      bus.clr_i        = clr;
      e = cyc + 1;
      if (clr) begin
         while (exp_q.size() > 0 && exp_q[$].edge_n >= e) void'(exp_q.pop_back());
         if (b_end > e) b_end = e;
         free_edge = e + 1;
      end else if (upd) begin
         if (e >= free_edge) begin
            r        = isqrt_ref(64'(d));
            x.root   = (r > MAXV) ? MAXV : r;
            x.sat    = (r > MAXV);
            x.edge_n = e + ITER;
            x.din    = 64'(d);
            exp_q.push_back(x);
            free_edge = e + ITER + 1;
            b_start   = e;
            b_end     = e + ITER;
         end else begin
            ovr_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [IN_W-1:0] d);
      drive_cycle(1'b1, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"},    bus.dout_o,        0);
      check({tag, "_update"},  bus.dout_update_o, 0);
      check({tag, "_busy"},    bus.busy_o,        0);
      check({tag, "_overrun"}, bus.overrun_o,     0);
      check({tag, "_sat"},     bus.sat_o,         0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("busy", bus.busy_o, (cyc >= b_start && cyc < b_end) ? 1 : 0);

            while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
               x = exp_q.pop_front();
               n_cmp++; n_bad++;
               $display("FAIL missing_strobe: actual=none required=strobe at cycle %0d for din %0d", x.edge_n, x.din);
            end
            if (bus.dout_update_o !== 1'b0) begin
               if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                  x = exp_q.pop_front();
                  n_cmp++;
                  check("dout", bus.dout_o, x.root);
                  check("sat",  bus.sat_o,  x.sat);
                  if (!x.sat)
                     check("root_bounds",
                           ((64'(bus.dout_o) * 64'(bus.dout_o) <= x.din) &&
                            ((64'(bus.dout_o) + 1) * (64'(bus.dout_o) + 1) > x.din)) ? 1 : 0, 1);
               end else begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_strobe: actual=strobe dout %0d required=no strobe (cycle %0d)", bus.dout_o, cyc);
               end
            end

            while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
               n_cmp++; n_bad++;
               $display("FAIL missing_overrun: actual=none required=pulse at cycle %0d", ovr_q.pop_front());
            end
            if (bus.overrun_o !== 1'b0) begin
               n_cmp++;
               if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
                  void'(ovr_q.pop_front());
               end else begin
                  n_bad++;
                  $display("FAIL unexpected_overrun: actual=pulse required=none (cycle %0d)", cyc);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [63:0]     t;
      logic [IN_W-1:0] d;
      longint unsigned k;

      bus.din_i        = '0;
      bus.din_update_i = 1'b0;
      bus.clr_i        = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n  = 1'b1;
      mon_on = 1'b1;
      idle(2);

      // Corner values, each left to complete.
      req(40'd0);             idle(ITER + 2);
      req(40'd1);             idle(ITER + 2);
      req(40'd99);            idle(ITER + 2);
      req(40'd100);           idle(ITER + 2);
      req(40'd4294836225);    idle(ITER + 2);
      req(40'd4294967296);    idle(ITER + 2);
      req({IN_W{1'b1}});      idle(ITER + 2);

      // Request while busy is dropped with an overrun pulse.
      req(40'd144); idle(4); req(40'd400); idle(ITER + 4);

      // Request in the strobe cycle is accepted: results 21 cycles apart.
      req(40'd144); idle(ITER); req(40'd400); idle(ITER + 4);

      // Abort at iteration 10.
      req(40'd1000); idle(9);
      drive_cycle(1'b0, '0, 1'b1);
      check("clr_busy", bus.busy_o, 0);
      check("clr_dout", bus.dout_o, 0);
      check("clr_sat",  bus.sat_o,  0);
      idle(ITER + 4);

      // Clear wins over a simultaneous request.
      drive_cycle(1'b1, 40'd50, 1'b1);
      check("clr_req_busy", bus.busy_o, 0);
      idle(ITER + 4);

      // Asynchronous reset mid-calculation.
      req(40'd12345); idle(7);
      rst_n = 1'b0;
      exp_q.delete();
      ovr_q.delete();
      free_edge = 0;
      b_end     = 0;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req(40'd10000); idle(ITER + 2);

      // Level-high request retriggers on every return to idle.
      for (int i = 0; i < 3 * (ITER + 1); i++) drive_cycle(1'b1, 40'd625, 1'b0);
      idle(ITER + 4);

      // Random radicands with gaps that sometimes collide with a busy calculation.
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 3))
            0: begin t = {$urandom, $urandom}; d = t[IN_W-1:0]; end
            1: d = IN_W'($urandom_range(0, 1000));
            2: begin
               k = longint'($urandom_range(1, (1 << 20) - 1));
               t = k * k - longint'($urandom_range(0, 1));
               d = t[IN_W-1:0];
            end
            default: begin t = {$urandom, $urandom}; d = {t[39:32], 32'hFFFF_0000 | t[31:0]}; end
         endcase
         req(d);
         idle($urandom_range(ITER - 3, ITER + 2));
      end

      idle(ITER + 10);
      check("drain_results",  exp_q.size(), 0);
      check("drain_overruns", ovr_q.size(), 0);
      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
